// File: rtl/button_event_detector.sv
// Turns a debounced switch level into one-cycle user events: press, release,
// short press, long press and auto-repeat while the button stays held.
module button_event_detector #(
   parameter int c_LONG_PRESS_CYCLES = 25000000,
   parameter int c_REPEAT_CYCLES     = 5000000,
   parameter int c_CNT_WIDTH         = 25
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Switch,
   output logic o_Held,
   output logic o_Press,
   output logic o_Release,
   output logic o_Short,
   output logic o_Long,
   output logic o_Repeat
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PRESSED = 2'd1;
   localparam logic [1:0] S_REPEAT  = 2'd2;

   localparam logic [c_CNT_WIDTH-1:0] CNT_ONE    = c_CNT_WIDTH'(1);
   localparam logic [c_CNT_WIDTH-1:0] LONG_CNT   = c_CNT_WIDTH'(c_LONG_PRESS_CYCLES);
   localparam logic [c_CNT_WIDTH-1:0] REPEAT_CNT = c_CNT_WIDTH'(c_REPEAT_CYCLES);

   logic [1:0]             state_q, state_d;
   logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   held_q, held_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   short_q, short_d;
   logic                   long_q, long_d;
   logic                   repeat_q, repeat_d;

   // The counter holds the number of edges since the last press or strobe,
   // so comparing it against the threshold hits the edge exactly on time.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      held_d    = held_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_Switch) begin
               state_d = S_PRESSED;
               cnt_d   = CNT_ONE;
               held_d  = 1'b1;
               press_d = 1'b1;
            end
         end
         S_PRESSED: begin
            if (!i_Switch) begin
               state_d   = S_IDLE;
               cnt_d     = '0;
               held_d    = 1'b0;
               release_d = 1'b1;
               short_d   = 1'b1;
            end else if (cnt_q == LONG_CNT) begin
               state_d = S_REPEAT;
               cnt_d   = CNT_ONE;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_REPEAT: begin
            // Release wins over a coinciding repeat edge.
            if (!i_Switch) begin
               state_d   = S_IDLE;
               cnt_d     = '0;
               held_d    = 1'b0;
               release_d = 1'b1;
            end else if (cnt_q == REPEAT_CNT) begin
               cnt_d    = CNT_ONE;
               repeat_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         held_q    <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         held_q    <= held_d;
         press_q   <= press_d;
         release_q <= release_d;
         short_q   <= short_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
      end
   end

   assign o_Held    = held_q;
   assign o_Press   = press_q;
   assign o_Release = release_q;
   assign o_Short   = short_q;
   assign o_Long    = long_q;
   assign o_Repeat  = repeat_q;

endmodule

// File: tb/tb_button_event_detector.sv
// Self-checking bench for button_event_detector: vector table, directed hold
// sequences and random switch activity against a time-based event model.
module tb_button_event_detector;

   localparam int L = 8;
   localparam int R = 3;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sw  = 1'b0;
   logic held, press, release_o, short_o, long_o, repeat_o;

   int total = 0;
   int bad   = 0;
   int edgeNum = 0;

   // Model state: whether the button is held and the edge number of the press.
   logic       mHeld = 1'b0;
   int         mE = 0;
   logic [5:0] mBits = 6'b0;

   typedef struct packed {
      logic       rst;
      logic       sw;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[$];

   button_event_detector #(
      .c_LONG_PRESS_CYCLES(L),
      .c_REPEAT_CYCLES(R),
      .c_CNT_WIDTH(W)
   ) dut (
      .i_Clk(clk),
      .i_Reset(rst),
      .i_Switch(sw),
      .o_Held(held),
      .o_Press(press),
      .o_Release(release_o),
      .o_Short(short_o),
      .o_Long(long_o),
      .o_Repeat(repeat_o)
   );

   always #20 clk = ~clk;

   // Bit order everywhere: {held, press, release, short, long, repeat}.
   function automatic logic [5:0] dutBits();
      return {held, press, release_o, short_o, long_o, repeat_o};
   endfunction

   task automatic checkOutput(input string name, input logic [5:0] exp);
      total++;
      if (dutBits() !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b", name, dutBits(), exp);
      end
   endtask

   // Events derived from elapsed edges since the press, not from a state machine.
   task automatic modelStep(input logic r, input logic s);
      int d;
      logic p, rl, sh, lg, rp;
      p = 1'b0; rl = 1'b0; sh = 1'b0; lg = 1'b0; rp = 1'b0;
      if (r) begin
         mHeld = 1'b0;
      end else if (!mHeld) begin
         if (s) begin
            p = 1'b1;
            mHeld = 1'b1;
            mE = edgeNum;
         end
      end else begin
         d = edgeNum - mE;
         if (!s) begin
            rl = 1'b1;
            sh = (d <= L);
            mHeld = 1'b0;
         end else if (d == L) begin
            lg = 1'b1;
         end else if (d > L && ((d - L) % R) == 0) begin
            rp = 1'b1;
         end
      end
      mBits = {mHeld, p, rl, sh, lg, rp};
   endtask

   task automatic applyStimulus(input logic r, input logic s, input string name);
      @(negedge clk);
      rst = r;
      sw = s;
      @(posedge clk);
      #1;
      edgeNum++;
      modelStep(r, s);
      checkOutput(name, mBits);
   endtask

   task automatic resetAll();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, "reset");
      applyStimulus(1'b0, 1'b0, "idle");
      checkOutput("reset state", 6'b000000);
   endtask

   initial begin
      logic rs, rr;
      int runLeft;

      resetAll();

      // Short press, minimum press, release on the threshold edge, reset mid-hold.
      vecs.push_back({1'b0, 1'b1, 6'b110000});
      for (int i = 0; i < 3; i++) vecs.push_back({1'b0, 1'b1, 6'b100000});
      vecs.push_back({1'b0, 1'b0, 6'b001100});
      vecs.push_back({1'b0, 1'b0, 6'b000000});
      vecs.push_back({1'b0, 1'b1, 6'b110000});
      vecs.push_back({1'b0, 1'b0, 6'b001100});
      vecs.push_back({1'b0, 1'b0, 6'b000000});
      vecs.push_back({1'b0, 1'b1, 6'b110000});
      for (int i = 1; i < L; i++) vecs.push_back({1'b0, 1'b1, 6'b100000});
      vecs.push_back({1'b0, 1'b0, 6'b001100});
      vecs.push_back({1'b0, 1'b0, 6'b000000});
      vecs.push_back({1'b0, 1'b1, 6'b110000});
      vecs.push_back({1'b1, 1'b1, 6'b000000});
      vecs.push_back({1'b0, 1'b1, 6'b110000});
      vecs.push_back({1'b0, 1'b0, 6'b001100});
      vecs.push_back({1'b0, 1'b0, 6'b000000});
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].sw, "vector model");
         checkOutput($sformatf("vector %0d", i), vecs[i].exp);
      end

      // Long press with repeats, released on the edge before a repeat would fire.
      resetAll();
      applyStimulus(1'b0, 1'b1, "long press");
      checkOutput("long press start", 6'b110000);
      for (int j = 1; j <= 17; j++) begin
         applyStimulus(1'b0, (j < 16), "long hold");
         if (j == 16)
            checkOutput("release after repeat", 6'b001000);
         else if (j == 17)
            checkOutput("no repeat after release", 6'b000000);
         else if (j == L)
            checkOutput("long strobe", 6'b100010);
         else if (j == 11 || j == 14)
            checkOutput($sformatf("repeat at %0d", j), 6'b100001);
         else
            checkOutput($sformatf("hold at %0d", j), 6'b100000);
      end

      // Reset during REPEAT with the switch still down.
      resetAll();
      applyStimulus(1'b0, 1'b1, "repeat reset press");
      for (int j = 1; j < 10; j++) applyStimulus(1'b0, 1'b1, "repeat reset hold");
      applyStimulus(1'b1, 1'b1, "reset in repeat");
      checkOutput("reset in repeat no release", 6'b000000);
      applyStimulus(1'b0, 1'b1, "press after reset");
      checkOutput("press after reset", 6'b110000);
      for (int j = 1; j <= L; j++) applyStimulus(1'b0, 1'b1, "hold after reset");
      checkOutput("long after reset", 6'b100010);

      // Immediate re-press on the edge after release.
      resetAll();
      applyStimulus(1'b0, 1'b1, "repress first");
      for (int j = 1; j < 4; j++) applyStimulus(1'b0, 1'b1, "repress hold");
      applyStimulus(1'b0, 1'b0, "repress release");
      checkOutput("repress release short", 6'b001100);
      applyStimulus(1'b0, 1'b1, "repress");
      checkOutput("repress press", 6'b110000);
      for (int j = 1; j <= L; j++) applyStimulus(1'b0, 1'b1, "repress hold2");
      checkOutput("repress long", 6'b100010);

      // Random switch runs with occasional resets.
      rs = 1'b0;
      runLeft = 0;
      for (int i = 0; i < 3000; i++) begin
         if (runLeft == 0) begin
            rs = ~rs;
            runLeft = $urandom_range(1, 25);
         end
         runLeft--;
         rr = ($urandom_range(0, 99) == 0);
         applyStimulus(rr, rs, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
